// File: rtl/cuca_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cuca_ram_pkg
// Brief    : Shared types and constants for the RAM access controller.
//            CTL_ prefix keeps the controller states apart from the RAM's own
//            STATE_ names.
// Revision : 1.0 - initial release
// ============================================================================
package cuca_ram_pkg;

    typedef enum logic [1:0] {
        CTL_IDLE = 2'd0,
        CTL_ADDR = 2'd1,
        CTL_DATA = 2'd2,
        CTL_DONE = 2'd3
    } ctl_state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Bits needed to hold a requester index (at least one).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker. Searches from ptr_i+1 upward,
//            wrapping modulo N_REQ, and reports the first active request.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IW    = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic             valid_o,
    output logic [IW-1:0]    winner_o
);

    // Walk candidates from farthest to nearest so the nearest active one wins.
    always_comb begin
        int          cand;
        logic [IW-1:0] cand_w;
        valid_o  = 1'b0;
        winner_o = '0;
        cand     = 0;
        cand_w   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand   = (int'(ptr_i) + k) % N_REQ;
            cand_w = IW'(cand);
            if (req_i[cand_w]) begin
                valid_o  = 1'b1;
                winner_o = cand_w;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_ctl.sv
`default_nettype none
// ============================================================================
// Module   : ram_ctl
// Brief    : Shares a single-port byte RAM on a tristate bus between N_REQ
//            requesters. Round-robin grant, then address phase, data phase
//            and a turnaround/done cycle. RAM/bus outputs are decoded from
//            state and latched registers only.
// Revision : 1.0 - initial release
// ============================================================================
module ram_ctl
    import cuca_ram_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       req_rw,
    input  logic [N_REQ*WIDTH-1:0] req_addr,
    input  logic [N_REQ*WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       rdata,
    output logic                   busy,
    output logic                   ram_enable,
    output logic                   ram_rw,
    output logic                   bus_drive,
    output logic [WIDTH-1:0]       bus_out,
    input  logic [WIDTH-1:0]       bus_in
);

    localparam int IW = idx_width(N_REQ);

    ctl_state_t        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     win_q, win_d;
    logic              rw_q, rw_d;
    logic [WIDTH-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;

    logic              w_pick_valid;
    logic [IW-1:0]     w_pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .valid_o  (w_pick_valid),
        .winner_o (w_pick_idx)
    );

    // State and latched-transaction registers; reset aborts any access.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CTL_IDLE;
            ptr_q   <= IW'(N_REQ - 1);
            win_q   <= '0;
            rw_q    <= RW_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state: grant in IDLE, sequence ADDR -> DATA -> DONE, capture reads.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            CTL_IDLE: begin
                if (w_pick_valid) begin
                    ptr_d   = w_pick_idx;
                    win_d   = w_pick_idx;
                    rw_d    = req_rw[w_pick_idx];
                    addr_d  = req_addr[int'(w_pick_idx)*WIDTH +: WIDTH];
                    wdata_d = req_wdata[int'(w_pick_idx)*WIDTH +: WIDTH];
                    state_d = CTL_ADDR;
                end
            end
            CTL_ADDR: state_d = CTL_DATA;
            CTL_DATA: begin
                if (rw_q == RW_READ) begin
                    rdata_d = bus_in;
                end
                state_d = CTL_DONE;
            end
            CTL_DONE: state_d = CTL_IDLE;
            default:  state_d = CTL_IDLE;
        endcase
    end

    // Output decode from state and latched registers only.
    always_comb begin
        done       = '0;
        busy       = (state_q != CTL_IDLE);
        ram_enable = 1'b0;
        ram_rw     = 1'b0;
        bus_drive  = 1'b0;
        bus_out    = '0;
        rdata      = rdata_q;
        case (state_q)
            CTL_ADDR: begin
                ram_enable = 1'b1;
                ram_rw     = rw_q;
                bus_drive  = 1'b1;
                bus_out    = addr_q;
            end
            CTL_DATA: begin
                ram_enable = 1'b1;
                ram_rw     = rw_q;
                if (rw_q == RW_WRITE) begin
                    bus_drive = 1'b1;
                    bus_out   = wdata_q;
                end
            end
            CTL_DONE: begin
                done[win_q] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
